// File: rtl/edge_lag_timer_pkg.sv
// rtl/edge_lag_timer_pkg.sv - shared types and helpers for the edge lag timer
package edge_lag_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        REPORT  = 2'd2
    } lag_state_t;

    localparam int DROP_CNT_W = 8;

    // Saturating increment: an all-ones count stays put.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/edge_lag_timer_if.sv
// rtl/edge_lag_timer_if.sv - result stream carrying the per-channel lag vector
interface edge_lag_timer_if #(
    parameter int N_CH  = 4,
    parameter int LAG_W = 10
);
    logic                  tvalid;
    logic                  tready;
    logic [N_CH*LAG_W-1:0] lag;
    logic [N_CH-1:0]       hit;

    modport master (output tvalid, output lag, output hit, input tready);
    modport slave  (input tvalid, input lag, input hit, output tready);
endinterface

// File: rtl/edge_lag_timer_capture.sv
// rtl/edge_lag_timer_capture.sv - first-edge lag capture for one measured channel
module lag_capture_channel #(
    parameter int LAG_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic             pulse_i,
    input  logic [LAG_W-1:0] count_i,
    output logic             hit_o,
    output logic [LAG_W-1:0] lag_o
);
    logic             hit_q;
    logic [LAG_W-1:0] lag_q;

    // Clear on a new window (a pulse on the trigger cycle counts as lag 0), then keep the first edge only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_q <= 1'b0;
            lag_q <= '0;
        end else if (clear_i) begin
            hit_q <= pulse_i;
            lag_q <= '0;
        end else if (enable_i && pulse_i && !hit_q) begin
            hit_q <= 1'b1;
            lag_q <= count_i;
        end
    end

    assign hit_o = hit_q;
    assign lag_o = lag_q;

endmodule

// File: rtl/edge_lag_timer.sv
// rtl/edge_lag_timer.sv - measures per-channel lag from a reference edge and reports it over a handshake
module edge_lag_timer
    import edge_lag_timer_pkg::*;
#(
    parameter int  N_CH    = 4,
    parameter int  MAX_LAG = 1024,
    localparam int LAG_W   = $clog2(MAX_LAG)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ref_edge_i,
    input  logic [N_CH-1:0]       sig_edge_i,
    edge_lag_timer_if.master      res_o,
    output logic [DROP_CNT_W-1:0] dropped_refs_o
);
    lag_state_t            state_q;
    logic [LAG_W-1:0]      count_q;
    logic                  valid_q;
    logic [DROP_CNT_W-1:0] drop_q;

    logic                  trigger;
    logic                  measuring;
    logic [LAG_W-1:0]      cur_count;
    logic                  all_hit;
    logic                  timeout;
    logic [N_CH-1:0]       hit_w;
    logic [N_CH*LAG_W-1:0] lag_w;

    // count_q holds elapsed cycles minus one, so the trigger cycle reads as lag 0 and the
    // first MEASURE cycle as lag 1.
    always_comb begin
        trigger   = (state_q == IDLE) && ref_edge_i;
        measuring = (state_q == MEASURE);
        cur_count = measuring ? count_q + LAG_W'(1) : '0;
        all_hit   = &(hit_w | sig_edge_i);
        timeout   = (cur_count == LAG_W'(MAX_LAG - 1));
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        lag_capture_channel #(.LAG_W(LAG_W)) u_ch (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .clear_i  (trigger),
            .enable_i (measuring),
            .pulse_i  (sig_edge_i[i]),
            .count_i  (cur_count),
            .hit_o    (hit_w[i]),
            .lag_o    (lag_w[i*LAG_W +: LAG_W])
        );
    end

    // Window FSM with registered valid, window counter and saturating busy-drop counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            valid_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            if ((state_q != IDLE) && ref_edge_i) begin
                drop_q <= sat_inc(drop_q);
            end
            case (state_q)
                IDLE: begin
                    if (ref_edge_i) begin
                        count_q <= '0;
                        // Every channel firing with the reference completes the set at once.
                        if (&sig_edge_i) begin
                            state_q <= REPORT;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= MEASURE;
                        end
                    end
                end
                MEASURE: begin
                    count_q <= count_q + LAG_W'(1);
                    if (all_hit || timeout) begin
                        state_q <= REPORT;
                        valid_q <= 1'b1;
                    end
                end
                REPORT: begin
                    if (res_o.tready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign res_o.tvalid   = valid_q;
    assign res_o.lag      = lag_w;
    assign res_o.hit      = hit_w;
    assign dropped_refs_o = drop_q;

endmodule

// File: tb/tb_edge_lag_timer.sv
// tb/tb_edge_lag_timer.sv - self-checking bench for edge_lag_timer
module tb_edge_lag_timer;
    localparam int N_CH    = 4;
    localparam int MAX_LAG = 32;
    localparam int LAG_W   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ref_edge = 1'b0;
    logic [N_CH-1:0] sig_edge = '0;
    logic [7:0]      dropped;

    int n_tests = 0;
    int n_fail  = 0;

    edge_lag_timer_if #(.N_CH(N_CH), .LAG_W(LAG_W)) res_if ();

    edge_lag_timer #(.N_CH(N_CH), .MAX_LAG(MAX_LAG)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ref_edge_i     (ref_edge),
        .sig_edge_i     (sig_edge),
        .res_o          (res_if),
        .dropped_refs_o (dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int lag_of(input int i);
        return int'(res_if.lag[i*LAG_W +: LAG_W]);
    endfunction

    // Timestamp model: a window opens at cycle t0, each channel's lag is the cycle
    // difference to its first pulse, the result appears once all channels hit or
    // MAX_LAG-1 cycles have elapsed, and stays until accepted.
    int       cyc = 0;
    int       m_t0 = 0;
    int       el;
    bit       m_meas = 0;
    bit       m_valid = 0;
    bit [3:0] m_hit = '0;
    int       m_lag [N_CH];
    int       m_drop = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_meas  = 0;
            m_valid = 0;
            m_hit   = '0;
            m_drop  = 0;
            foreach (m_lag[i]) m_lag[i] = 0;
        end else begin
            cyc++;
            if (!m_meas && !m_valid) begin
                if (ref_edge) begin
                    m_t0  = cyc;
                    m_hit = sig_edge;
                    foreach (m_lag[i]) m_lag[i] = 0;
                    if (m_hit == 4'hF) m_valid = 1;
                    else m_meas = 1;
                end
            end else if (m_meas) begin
                if (ref_edge && m_drop < 255) m_drop++;
                el = cyc - m_t0;
                for (int i = 0; i < N_CH; i++) begin
                    if (sig_edge[i] && !m_hit[i]) begin
                        m_hit[i] = 1'b1;
                        m_lag[i] = el;
                    end
                end
                if (m_hit == 4'hF || el == MAX_LAG - 1) begin
                    m_meas  = 0;
                    m_valid = 1;
                end
            end else begin
                if (ref_edge && m_drop < 255) m_drop++;
                if (res_if.tready) m_valid = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_valid", res_if.tvalid, m_valid);
        chk("model_dropped", dropped, m_drop);
        if (m_valid) begin
            chk("model_hit", res_if.hit, m_hit);
            for (int i = 0; i < N_CH; i++) chk("model_lag", lag_of(i), m_lag[i]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit [3:0] s);
        ref_edge = r;
        sig_edge = s;
        tick();
        ref_edge = 1'b0;
        sig_edge = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        res_if.tready = 1'b1;
        idle(3);
        chk("reset_valid", res_if.tvalid, 0);
        chk("reset_hit", res_if.hit, 0);
        chk("reset_lag", res_if.lag, 0);
        chk("reset_dropped", dropped, 0);
        rst = 1'b0;
        idle(2);

        // Stray edges while idle are ignored.
        drive(0, 4'hF);
        chk("idle_sig_ignored", res_if.tvalid, 0);

        // Test 1: lags 3,7,7,20.
        drive(1, 4'h0);
        idle(2);
        drive(0, 4'h1);
        idle(3);
        drive(0, 4'h6);
        idle(12);
        chk("t1_not_early", res_if.tvalid, 0);
        drive(0, 4'h8);
        chk("t1_valid", res_if.tvalid, 1);
        chk("t1_hit", res_if.hit, 4'hF);
        chk("t1_lag0", lag_of(0), 3);
        chk("t1_lag1", lag_of(1), 7);
        chk("t1_lag2", lag_of(2), 7);
        chk("t1_lag3", lag_of(3), 20);
        tick();
        chk("t1_valid_one_cycle", res_if.tvalid, 0);
        idle(1);

        // All channels firing with the reference.
        drive(1, 4'hF);
        chk("t7_valid", res_if.tvalid, 1);
        chk("t7_lag", res_if.lag, 0);
        tick();
        idle(1);

        // Test 2: timeout, with a capture on the last window cycle.
        drive(1, 4'h4);
        idle(30);
        chk("t2_not_early", res_if.tvalid, 0);
        drive(0, 4'h1);
        chk("t2_valid", res_if.tvalid, 1);
        chk("t2_hit", res_if.hit, 4'h5);
        chk("t2_lag0", lag_of(0), 31);
        chk("t2_lag2", lag_of(2), 0);
        chk("t2_lag1", lag_of(1), 0);
        tick();
        idle(1);

        // Test 3: first edge wins.
        drive(1, 4'h0);
        idle(3);
        drive(0, 4'h2);
        idle(4);
        drive(0, 4'h2);
        idle(2);
        drive(0, 4'hD);
        chk("t3_lag1", lag_of(1), 4);
        chk("t3_lag0", lag_of(0), 12);
        tick();
        idle(1);

        // Test 4: backpressure in REPORT with two busy references.
        res_if.tready = 1'b0;
        drive(1, 4'h0);
        idle(1);
        drive(0, 4'hF);
        for (int k = 0; k < 10; k++) begin
            drive(k == 3 || k == 7, (k == 5) ? 4'hF : 4'h0);
            chk("t4_held_valid", res_if.tvalid, 1);
            chk("t4_held_lag3", lag_of(3), 2);
        end
        chk("t4_dropped", dropped, 2);
        res_if.tready = 1'b1;
        tick();
        chk("t4_released", res_if.tvalid, 0);
        idle(1);

        // Test 5: saturating drop counter.
        res_if.tready = 1'b0;
        drive(1, 4'h0);
        ref_edge = 1'b1;
        idle(300);
        ref_edge = 1'b0;
        chk("t5_dropped_sat", dropped, 255);
        chk("t5_valid", res_if.tvalid, 1);
        res_if.tready = 1'b1;
        tick();
        chk("t5_released", res_if.tvalid, 0);
        idle(1);

        // Test 6: reset mid-measurement, then a clean window.
        drive(1, 4'h0);
        idle(1);
        drive(0, 4'h1);
        idle(2);
        rst = 1'b1;
        #1;
        chk("t6_valid", res_if.tvalid, 0);
        chk("t6_hit", res_if.hit, 0);
        chk("t6_lag", res_if.lag, 0);
        chk("t6_dropped", dropped, 0);
        tick();
        rst = 1'b0;
        idle(1);
        drive(1, 4'h0);
        drive(0, 4'hF);
        chk("t6_after_valid", res_if.tvalid, 1);
        chk("t6_after_lag0", lag_of(0), 1);
        tick();
        chk("t6_after_done", res_if.tvalid, 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
